// File: rtl/dpram_pkg.sv
// Shared types and defaults for the dual-port RAM read streamer.
package dpram_pkg;

  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rs_state_t;

  function automatic int dpram_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/dpram_skid_fifo.sv
// Two-entry synchronous FIFO; head entry is always a flop so the stream data is registered.
module dpram_skid_fifo
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]            occ_q, occ_d;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) e0_d = push_data;
        else               e1_d = push_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        // occupancy is unchanged; the new word lands behind whatever remains
        if (occ_q == 2'd2) begin
          e0_d = e1_q;
          e1_d = push_data;
        end else begin
          e0_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

  assign head      = e0_q;
  assign occupancy = occ_q;

endmodule

// File: rtl/dpram_read_streamer.sv
// Burst read sequencer for the simple dual-port RAM, streaming words through a 2-entry buffer.
// Define DPRAM_READ_STREAMER_LAST_EN to add the m_last end-of-burst marker.
//
// state | meaning
// IDLE  | waiting for start; a len=0 request only produces a done pulse
// READ  | issuing reads while the buffer plus in-flight read leaves room
// DRAIN | all reads issued, waiting for the last word to be accepted
module dpram_read_streamer
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  re,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
`ifdef DPRAM_READ_STREAMER_LAST_EN
  ,
  output logic                  m_last
`endif
);

`ifdef DPRAM_READ_STREAMER_LAST_EN
  localparam int FW = DATA_WIDTH + 1;
`else
  localparam int FW = DATA_WIDTH;
`endif

  rs_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_ptr_q, addr_ptr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic                  inflight_q, inflight_d;
  logic                  zero_done_q, zero_done_d;

  logic [1:0]            occupancy;
  logic [FW-1:0]         fifo_head, fifo_din;
  logic                  pop, issue, drain_done;
  logic [2:0]            level;

  assign pop        = m_valid & m_ready;
  // Slots committed after this cycle; a read may go out only if one is still free.
  assign level      = 3'(occupancy) + 3'(inflight_q) - 3'(pop);
  assign issue      = (state_q == READ) && (remaining_q != '0) && (level < 3'd2);
  assign drain_done = (state_q == DRAIN) && pop && (occupancy == 2'd1) && !inflight_q;

  always_comb begin
    state_d     = state_q;
    addr_ptr_d  = addr_ptr_q;
    remaining_d = remaining_q;
    inflight_d  = issue;
    zero_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d     = READ;
            addr_ptr_d  = base_addr;
            remaining_d = len;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (issue) begin
          addr_ptr_d  = addr_ptr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
          if (remaining_q == (ADDR_WIDTH+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_ptr_q  <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_ptr_q  <= addr_ptr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      zero_done_q <= zero_done_d;
    end
  end

`ifdef DPRAM_READ_STREAMER_LAST_EN
  logic inflight_last_q, inflight_last_d;

  assign inflight_last_d = issue && (remaining_q == (ADDR_WIDTH+1)'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) inflight_last_q <= 1'b0;
    else       inflight_last_q <= inflight_last_d;
  end

  assign fifo_din = {inflight_last_q, ram_dout};
  assign m_last   = m_valid & fifo_head[DATA_WIDTH];
`else
  assign fifo_din = ram_dout;
`endif

  dpram_skid_fifo #(
    .DATA_WIDTH(FW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_q),
    .push_data (fifo_din),
    .pop       (pop),
    .head      (fifo_head),
    .occupancy (occupancy)
  );

  assign busy    = (state_q != IDLE);
  assign done    = zero_done_q | drain_done;
  assign re      = issue;
  assign raddr   = addr_ptr_q;
  assign m_valid = (occupancy != 2'd0);
  assign m_data  = fifo_head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_dpram_read_streamer.sv
// Directed bench for dpram_read_streamer with a registered-read RAM model preloaded ram[i]=i.
module tb_dpram_read_streamer;
  localparam int DW = 4;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset, start, m_ready;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy, done, re, m_valid;
  logic [AW-1:0] raddr;
  logic [DW-1:0] ram_dout, m_data;
`ifdef DPRAM_READ_STREAMER_LAST_EN
  logic          m_last;
`endif

  always #5 clk = ~clk;

  dpram_read_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .re(re), .raddr(raddr), .ram_dout(ram_dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
`ifdef DPRAM_READ_STREAMER_LAST_EN
    , .m_last(m_last)
`endif
  );

  logic [DW-1:0] ram [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i);
    ram_dout = '0;
  end
  always @(posedge clk) if (re) ram_dout <= ram[raddr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // consumer ready: mode 0 always ready, 1 pattern 1,0,0,1 repeating, 2 never ready
  int ready_mode = 0;
  int ready_phase = 0;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (ready_phase % 4 == 0) || (ready_phase % 4 == 3);
        default: m_ready = 1'b0;
      endcase
      ready_phase++;
    end
  end

  // monitor: collects accepted words, issued addresses and done pulses; checks issue rule and stall hold
  logic [DW-1:0] got_q[$];
  logic          got_last_q[$];
  logic [AW-1:0] raddr_q[$];
  int            done_cnt = 0;
  int            b_occ = 0, b_inf = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        b_occ = 0; b_inf = 0; prev_stall = 1'b0;
      end else begin
        int pop;
        pop = (m_valid && m_ready) ? 1 : 0;
        if (prev_stall) begin
          check("stall_valid_hold", int'(m_valid), 1);
          check("stall_data_hold", int'(m_data), int'(prev_data));
        end
        check("valid_vs_model", int'(m_valid), (b_occ > 0) ? 1 : 0);
        if (re) begin
          check("re_room", (b_occ + b_inf - pop < 2) ? 1 : 0, 1);
          raddr_q.push_back(raddr);
        end
        if (pop == 1) begin
          got_q.push_back(m_data);
`ifdef DPRAM_READ_STREAMER_LAST_EN
          got_last_q.push_back(m_last);
`else
          got_last_q.push_back(1'b0);
`endif
        end
        if (done) done_cnt++;
        b_occ = b_occ + b_inf - pop;
        b_inf = re ? 1 : 0;
        prev_stall = m_valid && !m_ready;
        prev_data = m_data;
      end
    end
  end

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            mode;
    logic [DW-1:0] exp_first;
    logic [DW-1:0] exp_final;
    int            exp_words;
    bit            poke;
  } vec_t;

  task automatic run_vec(input vec_t v, input string name);
    int n;
    ready_mode = v.mode;
    ready_phase = 0;
    got_q.delete(); got_last_q.delete(); raddr_q.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = v.base; len = v.len;
    @(posedge clk); #1;
    start = 1'b0;
    if (v.poke) begin
      repeat (2) @(posedge clk);
      #1; start = 1'b1; base_addr = 4'd0; len = 5'd5;
      @(posedge clk); #1; start = 1'b0;
    end
    n = 0;
    while (done_cnt == 0 && n < 400) begin
      @(posedge clk); n++;
    end
    check({name, "_timeout"}, (n < 400) ? 1 : 0, 1);
    repeat (6) @(posedge clk);
    #1;
    check({name, "_busy_after"}, int'(busy), 0);
    check({name, "_done_count"}, done_cnt, 1);
    check({name, "_word_count"}, got_q.size(), v.exp_words);
    check({name, "_read_count"}, raddr_q.size(), v.exp_words);
    if (got_q.size() == v.exp_words && raddr_q.size() == v.exp_words) begin
      check({name, "_first"}, int'(got_q[0]), int'(v.exp_first));
      check({name, "_final"}, int'(got_q[v.exp_words-1]), int'(v.exp_final));
      for (int k = 0; k < v.exp_words; k++) begin
        int idx;
        idx = (int'(v.base) + k) % DEPTH;
        check($sformatf("%s_word%0d", name, k), int'(got_q[k]), int'(ram[idx]));
        check($sformatf("%s_raddr%0d", name, k), int'(raddr_q[k]), idx);
`ifdef DPRAM_READ_STREAMER_LAST_EN
        check($sformatf("%s_last%0d", name, k), int'(got_last_q[k]), (k == v.exp_words - 1) ? 1 : 0);
`endif
      end
    end
  endtask

  vec_t vecs[6];
  vec_t post_reset;

  initial begin
    vecs[0] = '{4'd2,  5'd4,  0, 4'd2,  4'd5,  4,  1'b0};
    vecs[1] = '{4'd14, 5'd4,  0, 4'd14, 4'd1,  4,  1'b0};
    vecs[2] = '{4'd0,  5'd16, 1, 4'd0,  4'd15, 16, 1'b0};
    vecs[3] = '{4'd9,  5'd1,  1, 4'd9,  4'd9,  1,  1'b0};
    vecs[4] = '{4'd4,  5'd3,  1, 4'd4,  4'd6,  3,  1'b1};
    vecs[5] = '{4'd15, 5'd16, 0, 4'd15, 4'd14, 16, 1'b0};
    post_reset = '{4'd5, 5'd1, 0, 4'd5, 4'd5, 1, 1'b0};

    reset = 1'b1; start = 1'b0; base_addr = '0; len = '0;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_re", int'(re), 0);
    check("rst_raddr", int'(raddr), 0);
    check("rst_valid", int'(m_valid), 0);
    check("rst_data", int'(m_data), 0);
`ifdef DPRAM_READ_STREAMER_LAST_EN
    check("rst_last", int'(m_last), 0);
`endif
    @(posedge clk); #1; reset = 1'b0;
    repeat (2) @(posedge clk);

    // cycle-exact burst: base 2, len 4, always ready
    ready_mode = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 4'd2; len = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("lat_c1_re", int'(re), 1);
    check("lat_c1_raddr", int'(raddr), 2);
    check("lat_c1_busy", int'(busy), 1);
    check("lat_c1_valid", int'(m_valid), 0);
    @(negedge clk);
    check("lat_c2_valid", int'(m_valid), 0);
    check("lat_c2_raddr", int'(raddr), 3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("lat_w%0d_valid", k), int'(m_valid), 1);
      check($sformatf("lat_w%0d_data", k), int'(m_data), 2 + k);
      check($sformatf("lat_w%0d_done", k), int'(done), (k == 3) ? 1 : 0);
      check($sformatf("lat_w%0d_busy", k), int'(busy), 1);
    end
    @(negedge clk);
    check("lat_end_busy", int'(busy), 0);
    check("lat_end_done", int'(done), 0);
    check("lat_end_valid", int'(m_valid), 0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // len = 0: done one cycle after start, no read, never busy
    raddr_q.delete(); done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 4'd7; len = 5'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("len0_done", int'(done), 1);
    check("len0_busy", int'(busy), 0);
    check("len0_re", int'(re), 0);
    @(negedge clk);
    check("len0_done_off", int'(done), 0);
    check("len0_busy2", int'(busy), 0);
    repeat (3) @(posedge clk);
    check("len0_no_reads", raddr_q.size(), 0);
    check("len0_done_count", done_cnt, 1);

    // reset during READ after two reads issued, consumer stalled
    ready_mode = 2;
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 4'd0; len = 5'd8;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("rmid_re1", int'(re), 1);
    @(negedge clk);
    check("rmid_re2", int'(re), 1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("rmid_valid", int'(m_valid), 0);
    check("rmid_re", int'(re), 0);
    check("rmid_busy", int'(busy), 0);
    check("rmid_done", int'(done), 0);
    check("rmid_raddr", int'(raddr), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rmid_no_done", done_cnt, 0);
    check("rmid_valid_after", int'(m_valid), 0);
    run_vec(post_reset, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dpram_read_streamer.md
Name: dpram_read_streamer

Overview:
- Read-side sequencer that sits directly downstream of the simple dual-port RAM.
- Accepts a burst command (base address and length), drives the RAM read port (re/raddr) and captures ram_dout one cycle later.
- Presents captured words on a valid/ready stream through a 2-entry buffer, so downstream backpressure never loses or duplicates data.
- Single clock domain; clk is the same clock that drives the RAM read port.

Parameters:
DATA_WIDTH  4  width of RAM word and stream data
ADDR_WIDTH  4  RAM address width; DEPTH = 1 << ADDR_WIDTH

Ports:
clk        input   1               clock; all logic on rising edge
reset      input   1               asynchronous, active-high reset
start      input   1               burst request; sampled only when busy=0
base_addr  input   ADDR_WIDTH      first RAM address of burst
len        input   ADDR_WIDTH+1    number of words, 0..DEPTH
busy       output  1               burst in progress
done       output  1               one-cycle pulse when burst completes
re         output  1               RAM read enable
raddr      output  ADDR_WIDTH      RAM read address
ram_dout   input   DATA_WIDTH      RAM registered read data (1-cycle latency after re)
m_data     output  DATA_WIDTH      stream data
m_valid    output  1               stream valid
m_ready    input   1               stream ready from consumer

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: busy=0, done=0, re=0, raddr=0, m_valid=0, m_data=0. All counters and buffer are emptied; state is IDLE.
- Reset mid-burst aborts immediately. No done pulse is produced and the buffer is flushed.
- FSM states: IDLE, READ, DRAIN.
  - IDLE: start=1 with len>0 -> READ. Latch base_addr into addr_ptr and len into remaining.
  - IDLE: start=1 with len=0 -> stay IDLE and pulse done the next cycle. No re is issued.
  - READ: when the final re is issued (remaining reaches 0) -> DRAIN.
  - DRAIN: when the last word is accepted (m_valid & m_ready) and no read is in flight -> IDLE, with done pulsed that cycle.
- busy=1 in READ and DRAIN. start is ignored while busy=1.
- Read issue rule: re=1 in READ when remaining>0 and (occupancy + inflight - pop) < 2.
  - occupancy: buffer entries, 0..2.
  - inflight: 1 if re was asserted last cycle.
  - pop: m_valid & m_ready this cycle.
- On each issued read: raddr=addr_ptr, addr_ptr increments, remaining decrements.
- Address arithmetic is modulo DEPTH. Example: base=14, len=4 reads 14, 15, 0, 1.
- Capture: when inflight=1, ram_dout is pushed into the buffer at the end of that cycle. The buffer can never overflow under the issue rule.
- Stream: m_valid = occupancy>0 and m_data = head entry. Data is held stable while m_valid=1 and m_ready=0 (AXI-style; valid never drops without a handshake).
- Latency: start sampled at edge E0; first re in the cycle after E0; first m_valid two cycles after that re.
- Throughput: with m_ready held at 1, one word per cycle after the first.
- len=DEPTH reads every address exactly once.
- Simultaneous push and pop keeps occupancy unchanged.

Optional Feature:
- Macro: DPRAM_READ_STREAMER_LAST_EN.
- Defined: adds output m_last (1 bit, reset 0). m_last=1 together with m_valid on the final word of the burst. A per-entry last flag is stored in the buffer.
- Undefined: port m_last and its storage are absent; all other behaviour is identical.

Decomposition:
- Package dpram_pkg holds:
  - Default DATA_WIDTH/ADDR_WIDTH localparams.
  - typedef enum logic [1:0] rs_state_t {IDLE, READ, DRAIN}.
  - A DEPTH helper function.
- Sub-module dpram_skid_fifo: 2-entry synchronous FIFO with push/pop, occupancy output and registered head. Parameterised by DATA_WIDTH (+1 when the LAST feature is enabled).

Test Plan:
- RAM preloaded ram[i]=i; start base=2, len=4, m_ready=1 -> m_data 2, 3, 4, 5 on consecutive cycles; done pulses once on the cycle word 5 is accepted; busy falls the next cycle.
- base=14, len=4 -> raddr sequence 14, 15, 0, 1 and m_data 14, 15, 0, 1 (wrap-around).
- base=0, len=16, m_ready toggling 1,0,0,1 repeating -> all 16 words delivered in order with no gap or duplicate, m_data stable while stalled, re never asserted with 2 words buffered+inflight.
- start with len=0 -> no re, done=1 exactly one cycle after start, busy stays 0.
- Assert reset during READ after 2 words issued, m_ready=0 -> next cycle m_valid=0, re=0, busy=0, and no done; then a new burst base=5, len=1 returns 5.
- With DPRAM_READ_STREAMER_LAST_EN: len=3 -> m_last=1 only on the third word; start pulsed while busy is ignored (no extra words).
